csr_mmode_unit: RTL and testbench
=================================

// Module: csr_mmode_unit
// PURPOSE
//  Parametrised machine-mode CSR file: successor of the fixed 32-bit CSR block.
//  Executes CSRRW/CSRRS/CSRRC in place, sequences trap entry and MRET, and owns the
//  mcycle/minstret/mtime counters. Raises the interrupt request to the pipeline control stage.
//  Sits beside the EX/MEM stage; the controller consumes trap_target_o / mepc_o for redirects.
// PARAMETERS
//  XLEN         32       data width of every CSR (32 or 64)
//  CNT_W        64       width of mcycle/minstret/mtime/mtimecmp (split hi/lo when XLEN=32)
//  MTVEC_RST    'h0      reset value of mtvec (low 2 bits = mode)
//  TIMER_EN     1        0 removes mtime/mtimecmp; MTIP then tied 0
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-low
//  csr_en_i      in   1       CSR instruction valid this cycle
//  csr_op_i      in   2       01=RW 10=RS 11=RC (00 = read-only access)
//  csr_addr_i    in   12      CSR address
//  csr_wdata_i   in   XLEN    rs1 value / zero-extended uimm
//  csr_rdata_o   out  XLEN    old CSR value (combinational)
//  illegal_o     out  1       access to unmapped address or write to read-only CSR
//  trap_valid_i  in   1       take trap this cycle
//  trap_cause_i  in   XLEN    mcause value; MSB=1 interrupt
//  trap_pc_i     in   XLEN    PC written to mepc
//  trap_val_i    in   XLEN    value written to mtval
//  mret_i        in   1       MRET retiring
//  retire_i      in   1       one instruction retired
//  ext_irq_i     in   1       external interrupt level (MEIP)
//  sw_irq_i      in   1       software interrupt level (MSIP)
//  irq_req_o     out  1       enabled interrupt pending
//  irq_cause_o   out  XLEN    cause for irq_req_o: MEI(11) > MSI(3) > MTI(7)
//  trap_target_o out  XLEN    redirect PC for a trap with trap_cause_i
//  mepc_o        out  XLEN    current mepc (MRET target)
// BEHAVIOUR
//  Map: mstatus 300, misa 301(RO), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342,
//   mtval 343, mip 344 (MEIP/MTIP RO, MSIP mirrors sw_irq_i, RO), mcycle B00/B80,
//   minstret B02/B82, mtime 7C0/7C1, mtimecmp 7C2/7C3 (hi halves only when XLEN=32).
//  Reset (rst=0, async): mstatus=0x1800 (MPP=11), mie=0, mtvec=MTVEC_RST, mscratch/mepc/
//   mcause/mtval=0, counters=0, mtimecmp=all ones; all outputs follow (irq_req_o=0).
//  Read: csr_rdata_o combinational from csr_addr_i; unmapped -> 0 with illegal_o=1.
//  Write at posedge when csr_en_i & op!=00 & !illegal_o & !trap_valid_i:
//   RW new=wdata; RS new=old|wdata; RC new=old&~wdata. RS/RC with wdata=0 -> no write.
//   illegal_o=1 -> no state change at all.
//  mepc bits[1:0] forced 0 on every write. mtvec mode>=2 reads back as 0 (direct).
//  Trap entry (trap_valid_i, 1 cycle): mepc=trap_pc_i&~3, mcause=trap_cause_i,
//   mtval=trap_val_i, MPIE=MIE, MIE=0, MPP=11. Any CSR write in the same cycle is dropped.
//  trap_target_o: mode 0 -> base; mode 1 & cause MSB=1 -> base + 4*cause[XLEN-2:0];
//   otherwise base. base = {mtvec[XLEN-1:2],2'b00}. Combinational.
//  MRET: MIE=MPIE, MPIE=1, MPP=11. trap_valid_i with mret_i: trap wins, MRET ignored.
//  Counters: mcycle +1 every cycle; minstret +1 when retire_i; mtime +1 every cycle.
//   All wrap modulo 2^CNT_W. A CSR write to any half wins over that cycle's increment.
//   A write to the lo half leaves hi unchanged (no carry that cycle).
//  MTIP = (mtime >= mtimecmp), unsigned, level; clears only by raising mtimecmp.
//  irq_req_o = MIE & |(mie & mip), registered (1-cycle latency from the level change).
//   irq_cause_o is registered with it, priority MEI > MSI > MTI.
//  Interrupt inputs are level; no latching in this block.
// TESTING
//  Reset: assert rst=0 mid-count -> all CSRs at reset values same cycle; mtimecmp=all ones.
//  CSRRS mie 0x888 then CSRRC 0x008 -> read 0x880; CSRRW misa -> illegal_o=1, value unchanged.
//  mtvec=0x101, MIE=1, mie.MEIE=1, ext_irq_i=1 -> irq_req_o=1 next cycle, cause 0x8000000B;
//   trap -> trap_target_o=0x12C, MIE=0, MPIE=1.
//  mtimecmp=mtime+5 -> MTIP after 5 cycles; irq follows 1 cycle later; rewrite mtimecmp clears.
//  Trap and CSRRW mscratch same cycle -> mscratch unchanged; trap and MRET -> trap state only.
//  mcycle lo=0xFFFFFFFF (XLEN=32) -> next cycle lo=0, hi+1; write lo same cycle -> write wins.

Source files
------------

// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC execution, trap entry / MRET sequencing,
// mcycle/minstret/mtime counters and the registered interrupt request.
module csr_mmode_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter bit              TIMER_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic            ext_irq_i,
  input  logic            sw_irq_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o
);
  localparam int unsigned     DW          = 2 * XLEN;
  localparam logic [XLEN-1:0] MSTATUS_FIX = XLEN'(32'h1800);
  localparam logic [XLEN-1:0] MSTATUS_WM  = XLEN'(32'h88);
  localparam logic [XLEN-1:0] MIE_WM      = XLEN'(32'h888);
  localparam logic [1:0]      MXL         = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA        = (XLEN'(MXL) << (XLEN - 2)) | XLEN'(32'h100);
  localparam logic [XLEN-1:0] IRQ_FLAG    = XLEN'(1) << (XLEN - 1);

  logic [XLEN-1:0]  mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [CNT_W-1:0] mcycle_q, minstret_q, mtime_q, mtimecmp_q;
  logic [XLEN-1:0]  mip, pend, rdata, wr_new, irq_cause_q;
  logic             mapped, ro, wr_intent, do_wr, mtip, irq_req_q;

  // Counters are viewed through a 2*XLEN window so hi/lo halves slice uniformly.
  function automatic logic [XLEN-1:0] lo_of(input logic [CNT_W-1:0] c);
    logic [DW-1:0] w;
    w = '0; w[CNT_W-1:0] = c;
    return w[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] hi_of(input logic [CNT_W-1:0] c);
    logic [DW-1:0] w;
    w = '0; w[CNT_W-1:0] = c;
    return w[DW-1:XLEN];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc,
                                                input logic wr_lo, input logic wr_hi,
                                                input logic [XLEN-1:0] d);
    logic [DW-1:0] w;
    w = '0; w[CNT_W-1:0] = c;
    if (wr_lo)      w[XLEN-1:0] = d;
    else if (wr_hi) w[DW-1:XLEN] = d;
    else if (inc)   w[CNT_W-1:0] = c + CNT_W'(1);
    return w[CNT_W-1:0];
  endfunction

  assign mtip = TIMER_EN && (mtime_q >= mtimecmp_q);

  always_comb begin
    mip     = '0;
    mip[11] = ext_irq_i;
    mip[7]  = mtip;
    mip[3]  = sw_irq_i;
  end
  assign pend = mie_q & mip;

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    ro     = 1'b0;
    case (csr_addr_i)
      12'h300: rdata = mstatus_q;
      12'h301: begin rdata = MISA; ro = 1'b1; end
      12'h304: rdata = mie_q;
      12'h305: rdata = {mtvec_q[XLEN-1:2], mtvec_q[1] ? 2'b00 : mtvec_q[1:0]};
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: begin rdata = mip; ro = 1'b1; end
      12'hB00: rdata = lo_of(mcycle_q);
      12'hB02: rdata = lo_of(minstret_q);
      12'hB80: if (XLEN == 32) rdata = hi_of(mcycle_q);   else mapped = 1'b0;
      12'hB82: if (XLEN == 32) rdata = hi_of(minstret_q); else mapped = 1'b0;
      12'h7C0: if (TIMER_EN) rdata = lo_of(mtime_q);    else mapped = 1'b0;
      12'h7C2: if (TIMER_EN) rdata = lo_of(mtimecmp_q); else mapped = 1'b0;
      12'h7C1: if (TIMER_EN && XLEN == 32) rdata = hi_of(mtime_q);    else mapped = 1'b0;
      12'h7C3: if (TIMER_EN && XLEN == 32) rdata = hi_of(mtimecmp_q); else mapped = 1'b0;
      default: mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero mask never writes, so it may touch read-only CSRs.
  assign wr_intent   = (csr_op_i == 2'b01) || (csr_op_i[1] && (|csr_wdata_i));
  assign illegal_o   = !mapped || (ro && wr_intent);
  assign csr_rdata_o = rdata;
  assign do_wr       = csr_en_i && wr_intent && !illegal_o && !trap_valid_i;

  always_comb begin
    case (csr_op_i)
      2'b10:   wr_new = rdata | csr_wdata_i;
      2'b11:   wr_new = rdata & ~csr_wdata_i;
      default: wr_new = csr_wdata_i;
    endcase
  end

  always_comb begin
    trap_target_o = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
      trap_target_o = trap_target_o + XLEN'({trap_cause_i[XLEN-2:0], 2'b00});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q   <= MSTATUS_FIX;
      mie_q       <= '0;
      mtvec_q     <= MTVEC_RST;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      irq_req_q   <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      if (trap_valid_i) begin
        mepc_q       <= trap_pc_i & ~XLEN'(3);
        mcause_q     <= trap_cause_i;
        mtval_q      <= trap_val_i;
        mstatus_q[7] <= mstatus_q[3];
        mstatus_q[3] <= 1'b0;
      end else if (mret_i) begin
        mstatus_q[3] <= mstatus_q[7];
        mstatus_q[7] <= 1'b1;
      end else if (do_wr && csr_addr_i == 12'h300) begin
        mstatus_q <= (wr_new & MSTATUS_WM) | MSTATUS_FIX;
      end
      if (do_wr) begin
        case (csr_addr_i)
          12'h304: mie_q      <= wr_new & MIE_WM;
          12'h305: mtvec_q    <= wr_new;
          12'h340: mscratch_q <= wr_new;
          12'h341: mepc_q     <= wr_new & ~XLEN'(3);
          12'h342: mcause_q   <= wr_new;
          12'h343: mtval_q    <= wr_new;
          default: ;
        endcase
      end
      mcycle_q   <= cnt_next(mcycle_q, 1'b1, do_wr && csr_addr_i == 12'hB00,
                             do_wr && csr_addr_i == 12'hB80, wr_new);
      minstret_q <= cnt_next(minstret_q, retire_i, do_wr && csr_addr_i == 12'hB02,
                             do_wr && csr_addr_i == 12'hB82, wr_new);
      if (TIMER_EN) begin
        mtime_q    <= cnt_next(mtime_q, 1'b1, do_wr && csr_addr_i == 12'h7C0,
                               do_wr && csr_addr_i == 12'h7C1, wr_new);
        mtimecmp_q <= cnt_next(mtimecmp_q, 1'b0, do_wr && csr_addr_i == 12'h7C2,
                               do_wr && csr_addr_i == 12'h7C3, wr_new);
      end
      irq_req_q <= mstatus_q[3] && (|pend);
      if (!mstatus_q[3])  irq_cause_q <= '0;
      else if (pend[11])  irq_cause_q <= IRQ_FLAG | XLEN'(11);
      else if (pend[3])   irq_cause_q <= IRQ_FLAG | XLEN'(3);
      else if (pend[7])   irq_cause_q <= IRQ_FLAG | XLEN'(7);
      else                irq_cause_q <= '0;
    end
  end

  assign irq_req_o   = irq_req_q;
  assign irq_cause_o = irq_cause_q;
  assign mepc_o      = mepc_q;
endmodule

// File: tb/tb_csr_mmode_unit.sv
// Directed bench for csr_mmode_unit (XLEN=32, CNT_W=64, timer enabled).
module tb_csr_mmode_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_en_i = 1'b0;
  logic [1:0]  csr_op_i = 2'b00;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        illegal_o;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_cause_i = '0, trap_pc_i = '0, trap_val_i = '0;
  logic        mret_i = 1'b0, retire_i = 1'b0, ext_irq_i = 1'b0, sw_irq_i = 1'b0;
  logic        irq_req_o;
  logic [31:0] irq_cause_o, trap_target_o, mepc_o;

  int checks = 0;
  int failures = 0;

  csr_mmode_unit #(.XLEN(32), .CNT_W(64), .MTVEC_RST(32'h0), .TIMER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .illegal_o(illegal_o),
    .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_val_i(trap_val_i), .mret_i(mret_i), .retire_i(retire_i), .ext_irq_i(ext_irq_i),
    .sw_irq_i(sw_irq_i), .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
    .trap_target_o(trap_target_o), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_en_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    cyc();
    csr_en_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_addr_i = a; #1; v = csr_rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    cyc(); cyc(); rst = 1'b1;
    repeat (8) cyc();
    #2 rst = 1'b0;
    rd(12'h300, v); checks++;
    if (v !== 32'h1800) begin failures++; $display("FAIL rst_mstatus got=%h exp=%h", v, 32'h1800); end
    rd(12'hB00, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL rst_mcycle got=%h exp=0", v); end
    rd(12'h7C3, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_mtimecmp_hi got=%h exp=ffffffff", v); end
    rd(12'h305, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL rst_mtvec got=%h exp=0", v); end
    checks++;
    if (irq_req_o !== 1'b0 || mepc_o !== 32'h0) begin
      failures++; $display("FAIL rst_outputs irq=%b mepc=%h exp irq=0 mepc=0", irq_req_o, mepc_o);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_csr_ops();
    logic [31:0] v;
    csr_cmd(2'b10, 12'h304, 32'h888);
    csr_cmd(2'b11, 12'h304, 32'h008);
    rd(12'h304, v); checks++;
    if (v !== 32'h880) begin failures++; $display("FAIL mie_rs_rc got=%h exp=880", v); end
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h301; csr_wdata_i = 32'hFFFF_FFFF;
    #1 checks++;
    if (illegal_o !== 1'b1) begin failures++; $display("FAIL misa_illegal got=%b exp=1", illegal_o); end
    cyc(); csr_en_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
    rd(12'h301, v); checks++;
    if (v !== 32'h4000_0100) begin failures++; $display("FAIL misa_value got=%h exp=40000100", v); end
    rd(12'h123, v); checks++;
    if (v !== 32'h0 || illegal_o !== 1'b1) begin
      failures++; $display("FAIL unmapped got=%h/%b exp=0/1", v, illegal_o);
    end
    csr_cmd(2'b01, 12'h341, 32'h0000_1003);
    rd(12'h341, v); checks++;
    if (v !== 32'h1000) begin failures++; $display("FAIL mepc_align got=%h exp=1000", v); end
    csr_cmd(2'b01, 12'h305, 32'h0000_0102);
    rd(12'h305, v); checks++;
    if (v !== 32'h100) begin failures++; $display("FAIL mtvec_mode2 got=%h exp=100", v); end
  endtask

  task automatic test_irq_trap();
    logic [31:0] v;
    csr_cmd(2'b01, 12'h305, 32'h101);
    csr_cmd(2'b10, 12'h300, 32'h8);
    ext_irq_i = 1'b1; #1 checks++;
    if (irq_req_o !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq_req_o); end
    cyc(); checks++;
    if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_000B) begin
      failures++; $display("FAIL irq_mei got=%b/%h exp=1/8000000b", irq_req_o, irq_cause_o);
    end
    trap_valid_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h2002; trap_val_i = 32'h0;
    #1 checks++;
    if (trap_target_o !== 32'h12C) begin failures++; $display("FAIL trap_vector got=%h exp=12c", trap_target_o); end
    cyc(); trap_valid_i = 1'b0;
    rd(12'h300, v); checks++;
    if (v !== 32'h1880 || mepc_o !== 32'h2000) begin
      failures++; $display("FAIL trap_entry mstatus=%h mepc=%h exp 1880/2000", v, mepc_o);
    end
    cyc(); checks++;
    if (irq_req_o !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq_req_o); end
    ext_irq_i = 1'b0;
    mret_i = 1'b1; cyc(); mret_i = 1'b0;
    rd(12'h300, v); checks++;
    if (v !== 32'h1888) begin failures++; $display("FAIL mret got=%h exp=1888", v); end
    csr_cmd(2'b10, 12'h304, 32'h008);
    sw_irq_i = 1'b1; cyc(); checks++;
    if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0003) begin
      failures++; $display("FAIL irq_msi got=%b/%h exp=1/80000003", irq_req_o, irq_cause_o);
    end
    ext_irq_i = 1'b1; cyc(); checks++;
    if (irq_cause_o !== 32'h8000_000B) begin failures++; $display("FAIL irq_prio got=%h exp=8000000b", irq_cause_o); end
    ext_irq_i = 1'b0; sw_irq_i = 1'b0;
    csr_cmd(2'b11, 12'h304, 32'h008);
    csr_cmd(2'b11, 12'h300, 32'h008);
  endtask

  task automatic test_timer();
    logic [31:0] v, m;
    csr_cmd(2'b10, 12'h300, 32'h8);
    csr_cmd(2'b01, 12'h7C3, 32'h0);
    rd(12'h7C0, m);
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h7C2; csr_wdata_i = m + 32'd5;
    cyc(); csr_en_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
    cyc(); cyc(); cyc();
    rd(12'h344, v); checks++;
    if (v[7] !== 1'b0) begin failures++; $display("FAIL mtip_early got=%b exp=0", v[7]); end
    cyc();
    rd(12'h344, v); checks++;
    if (v[7] !== 1'b1 || irq_req_o !== 1'b0) begin
      failures++; $display("FAIL mtip_set mtip=%b irq=%b exp 1/0", v[7], irq_req_o);
    end
    cyc(); checks++;
    if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0007) begin
      failures++; $display("FAIL irq_mti got=%b/%h exp=1/80000007", irq_req_o, irq_cause_o);
    end
    csr_cmd(2'b01, 12'h7C2, 32'hFFFF_FFFF);
    rd(12'h344, v); checks++;
    if (v[7] !== 1'b0) begin failures++; $display("FAIL mtip_clear got=%b exp=0", v[7]); end
    cyc(); checks++;
    if (irq_req_o !== 1'b0) begin failures++; $display("FAIL irq_mti_clear got=%b exp=0", irq_req_o); end
    csr_cmd(2'b11, 12'h300, 32'h8);
  endtask

  task automatic test_trap_collide();
    logic [31:0] v;
    csr_cmd(2'b01, 12'h340, 32'h55);
    trap_valid_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h3001; trap_val_i = 32'hDEAD;
    mret_i = 1'b1; csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h340; csr_wdata_i = 32'hAA;
    #1 checks++;
    if (trap_target_o !== 32'h100) begin failures++; $display("FAIL trap_sync_target got=%h exp=100", trap_target_o); end
    cyc();
    trap_valid_i = 1'b0; mret_i = 1'b0; csr_en_i = 1'b0; csr_op_i = 2'b00; csr_wdata_i = '0;
    rd(12'h340, v); checks++;
    if (v !== 32'h55) begin failures++; $display("FAIL trap_drops_write got=%h exp=55", v); end
    rd(12'h300, v); checks++;
    if (v !== 32'h1800) begin failures++; $display("FAIL trap_beats_mret got=%h exp=1800", v); end
    rd(12'h343, v); checks++;
    if (v !== 32'hDEAD || mepc_o !== 32'h3000) begin
      failures++; $display("FAIL trap_regs mtval=%h mepc=%h exp dead/3000", v, mepc_o);
    end
  endtask

  task automatic test_counters();
    logic [31:0] lo, hi;
    csr_cmd(2'b01, 12'hB80, 32'h5);
    csr_cmd(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, lo); rd(12'hB80, hi); checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h5) begin
      failures++; $display("FAIL mcycle_wr got=%h_%h exp=00000005_ffffffff", hi, lo);
    end
    cyc();
    rd(12'hB00, lo); rd(12'hB80, hi); checks++;
    if (lo !== 32'h0 || hi !== 32'h6) begin
      failures++; $display("FAIL mcycle_carry got=%h_%h exp=00000006_00000000", hi, lo);
    end
    csr_cmd(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_cmd(2'b01, 12'hB00, 32'h10);
    rd(12'hB00, lo); rd(12'hB80, hi); checks++;
    if (lo !== 32'h10 || hi !== 32'h6) begin
      failures++; $display("FAIL mcycle_wr_wins got=%h_%h exp=00000006_00000010", hi, lo);
    end
    csr_cmd(2'b01, 12'hB02, 32'h0);
    retire_i = 1'b1; cyc(); cyc(); cyc(); retire_i = 1'b0;
    rd(12'hB02, lo); checks++;
    if (lo !== 32'h3) begin failures++; $display("FAIL minstret got=%h exp=3", lo); end
    retire_i = 1'b1; csr_cmd(2'b01, 12'hB02, 32'd100); retire_i = 1'b0;
    rd(12'hB02, lo); checks++;
    if (lo !== 32'd100) begin failures++; $display("FAIL minstret_wr_wins got=%h exp=64", lo); end
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_irq_trap();
    test_timer();
    test_trap_collide();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
